// File: rtl/crtc_timing_seq_if.sv
// Pixel-timing bus for crtc_timing_seq: config write port in, raster timing out.
interface crtc_timing_seq_if;
  logic        pix_en;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_wdata;
  logic        cfg_pending;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] hpos;
  logic [11:0] vpos;
  logic        line_start;
  logic        frame_start;

  modport master (
    output pix_en, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_pending, hsync, vsync, de, hpos, vpos, line_start, frame_start
  );

  modport slave (
    input  pix_en, cfg_we, cfg_addr, cfg_wdata,
    output cfg_pending, hsync, vsync, de, hpos, vpos, line_start, frame_start
  );
endinterface

// File: rtl/crtc_timing_seq.sv
// CRT timing sequencer: H/V segment FSMs with shadowed timing registers that
// swap in only at the frame boundary, so a frame never mixes two configurations.
module crtc_timing_seq #(
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  // Reset value of each timing register, indexed by cfg_addr.
  parameter logic [7:0][11:0] RST_TIMING = {12'd33, 12'd2, 12'd10, 12'd480,
                                            12'd48, 12'd96, 12'd16, 12'd640}
) (
  input  logic             clk,
  input  logic             reset,
  crtc_timing_seq_if.slave bus
);

  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FP     = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BP     = 2'd3
  } seg_t;

  seg_t             hstate, vstate;
  logic [11:0]      hcnt, vcnt;
  logic [11:0]      hlen, vlen, hlast, vlast;
  logic [7:0][11:0] shadow, active;
  logic             hend, vend, line_end, frame_end;
  logic             pending, line_start_q, frame_start_q;

  // Segment encoding doubles as the register index: h regs 0-3, v regs 4-7.
  assign hlen  = active[{1'b0, hstate}];
  assign vlen  = active[{1'b1, vstate}];
  assign hlast = (hlen == 12'd0) ? 12'd0 : hlen - 12'd1;
  assign vlast = (vlen == 12'd0) ? 12'd0 : vlen - 12'd1;

  assign hend      = (hcnt >= hlast);
  assign vend      = (vcnt >= vlast);
  assign line_end  = (hstate == SEG_BP) && hend;
  assign frame_end = line_end && (vstate == SEG_BP) && vend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hstate        <= SEG_ACTIVE;
      vstate        <= SEG_ACTIVE;
      hcnt          <= 12'd0;
      vcnt          <= 12'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (bus.pix_en) begin
        if (hend) begin
          hcnt   <= 12'd0;
          hstate <= seg_t'(hstate + 2'd1);
        end else begin
          hcnt <= hcnt + 12'd1;
        end
        if (line_end) begin
          line_start_q  <= 1'b1;
          frame_start_q <= (vstate == SEG_BP) && vend;
          if (vend) begin
            vcnt   <= 12'd0;
            vstate <= seg_t'(vstate + 2'd1);
          end else begin
            vcnt <= vcnt + 12'd1;
          end
        end
      end
    end
  end

  // A write landing on the boundary edge goes to shadow after the copy,
  // so it is held for the following frame and keeps pending set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= RST_TIMING;
      active  <= RST_TIMING;
      pending <= 1'b0;
    end else begin
      if (bus.pix_en && frame_end) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (bus.cfg_we) begin
        shadow[bus.cfg_addr] <= bus.cfg_wdata;
        pending              <= 1'b1;
      end
    end
  end

  assign bus.cfg_pending = pending;
  assign bus.de          = (hstate == SEG_ACTIVE) && (vstate == SEG_ACTIVE);
  assign bus.hsync       = (hstate == SEG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
  assign bus.vsync       = (vstate == SEG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
  assign bus.hpos        = (hstate == SEG_ACTIVE) ? hcnt : 12'd0;
  assign bus.vpos        = (vstate == SEG_ACTIVE) ? vcnt : 12'd0;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule
